// File: rtl/dma_pkg.sv
// dma_pkg: shared types for the DMA descriptor path.
// Descriptors carry their target engine in the chan field.
package dma_pkg;

    localparam int DMA_MAX_CHANNELS = 16;

    typedef logic [3:0] t_dma_chan_id;

    typedef struct packed {
        t_dma_chan_id chan;
        logic [31:0]  src_addr;
        logic [31:0]  dst_addr;
        logic [15:0]  len;
    } t_dma_descriptor;

    typedef enum logic [1:0] {
        EMPTY,
        DECODE,
        OFFER
    } t_dispatch_state;

endpackage

// File: rtl/dma_chan_credit.sv
// dma_chan_credit: in-flight counter for one copy engine.
// A completion on an idle channel is refused and flagged as underflow.
module dma_chan_credit #(
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    output logic avail,
    output logic dec_ok,
    output logic underflow
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    assign avail     = count < CW'(LIMIT);
    assign dec_ok    = dec && (count != '0);
    assign underflow = dec && (count == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count + CW'(inc) - CW'(dec_ok);
        end
    end

endmodule

// File: rtl/dma_desc_dispatch.sv
// dma_desc_dispatch: queues descriptors and hands them in order to
// per-channel copy engines under global and per-channel credit limits.
module dma_desc_dispatch
    import dma_pkg::*;
#(
    parameter int NUM_CHANNELS       = 4,
    parameter int FIFO_DEPTH         = 16,
    parameter int MAX_REQS_IN_FLIGHT = 32,
    parameter int MAX_PER_CHANNEL    = 8
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      desc_in_valid,
    output logic                                      desc_in_ready,
    input  t_dma_descriptor                           desc_in,
    output logic [NUM_CHANNELS-1:0]                   ch_desc_valid,
    input  logic [NUM_CHANNELS-1:0]                   ch_desc_ready,
    output t_dma_descriptor                           ch_desc,
    input  logic [NUM_CHANNELS-1:0]                   ch_done,
    input  logic                                      flush,
    output logic [$clog2(MAX_REQS_IN_FLIGHT+1)-1:0]   in_flight,
    output logic [31:0]                               done_count,
    output logic                                      bad_chan_err,
    output logic                                      idle
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(MAX_REQS_IN_FLIGHT + 1);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    t_dma_descriptor mem [FIFO_DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr, occ;
    logic            empty, full, push, pop;
    t_dma_descriptor head;

    t_dispatch_state state, state_nxt;
    t_dma_descriptor out_q;
    logic            head_bad, head_ok, load, drop, hs;
    logic            stay, stay_after_pop;
    logic [IW-1:0]   n_done;

    logic [NUM_CHANNELS-1:0] inc, avail, dec_ok, underflow;

    assign occ           = wr_ptr - rd_ptr;
    assign empty         = wr_ptr == rd_ptr;
    assign full          = occ == (AW+1)'(FIFO_DEPTH);
    assign desc_in_ready = !full;
    assign push          = desc_in_valid && desc_in_ready && !flush;
    assign head          = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= desc_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    assign head_bad = int'(head.chan) >= NUM_CHANNELS;

    always_comb begin
        head_ok = 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (head.chan == t_dma_chan_id'(i)) head_ok = avail[i];
        end
    end

    // Does the queue still hold something once this edge has been taken?
    assign stay           = !flush && (push || !empty);
    assign stay_after_pop = !flush && (push || occ > PTR_ONE);

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load      = 1'b0;
        drop      = 1'b0;
        unique case (state)
            EMPTY: begin
                if (stay) state_nxt = DECODE;
            end
            DECODE: begin
                if (flush) begin
                    state_nxt = EMPTY;
                end else if (head_bad) begin
                    pop       = 1'b1;
                    drop      = 1'b1;
                    state_nxt = stay_after_pop ? DECODE : EMPTY;
                end else if (head_ok &&
                             in_flight < IW'(MAX_REQS_IN_FLIGHT)) begin
                    pop       = 1'b1;
                    load      = 1'b1;
                    state_nxt = OFFER;
                end
            end
            OFFER: begin
                if (hs) state_nxt = stay ? DECODE : EMPTY;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
            out_q <= '0;
        end else begin
            state <= state_nxt;
            if (load) out_q <= head;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            ch_desc_valid[i] = (state == OFFER) &&
                               (out_q.chan == t_dma_chan_id'(i));
        end
    end

    assign ch_desc = out_q;
    assign inc     = ch_desc_valid & ch_desc_ready;
    assign hs      = |inc;

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_credit
        dma_chan_credit #(
            .LIMIT (MAX_PER_CHANNEL)
        ) u_credit (
            .clk       (clk),
            .reset     (reset),
            .inc       (inc[g]),
            .dec       (ch_done[g]),
            .avail     (avail[g]),
            .dec_ok    (dec_ok[g]),
            .underflow (underflow[g])
        );
    end

    // Only accepted completions are counted; the limits bound the sum.
    assign n_done = IW'($countones(dec_ok));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_flight    <= '0;
            done_count   <= '0;
            bad_chan_err <= 1'b0;
        end else begin
            in_flight    <= in_flight + IW'(hs) - n_done;
            done_count   <= done_count + 32'(n_done);
            bad_chan_err <= bad_chan_err | drop | (|underflow);
        end
    end

    assign idle = empty && (state != OFFER) && (in_flight == '0);

endmodule

// File: tb/tb_dma_desc_dispatch.sv
// tb_dma_desc_dispatch: cycle vectors, directed corner cases and a random
// run checked against a transaction-level model of the dispatcher.
module tb_dma_desc_dispatch;
    import dma_pkg::*;

    localparam int NCH   = 4;
    localparam int DEPTH = 16;
    localparam int MAXG  = 32;
    localparam int MAXC  = 8;
    localparam int IW    = $clog2(MAXG + 1);

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 desc_in_valid;
    logic                 desc_in_ready;
    t_dma_descriptor      desc_in;
    logic [NCH-1:0]       ch_desc_valid;
    logic [NCH-1:0]       ch_desc_ready;
    t_dma_descriptor      ch_desc;
    logic [NCH-1:0]       ch_done;
    logic                 flush;
    logic [IW-1:0]        in_flight;
    logic [31:0]          done_count;
    logic                 bad_chan_err;
    logic                 idle;

    always #5 clk = ~clk;

    dma_desc_dispatch #(
        .NUM_CHANNELS       (NCH),
        .FIFO_DEPTH         (DEPTH),
        .MAX_REQS_IN_FLIGHT (MAXG),
        .MAX_PER_CHANNEL    (MAXC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .desc_in_valid (desc_in_valid),
        .desc_in_ready (desc_in_ready),
        .desc_in       (desc_in),
        .ch_desc_valid (ch_desc_valid),
        .ch_desc_ready (ch_desc_ready),
        .ch_desc       (ch_desc),
        .ch_done       (ch_done),
        .flush         (flush),
        .in_flight     (in_flight),
        .done_count    (done_count),
        .bad_chan_err  (bad_chan_err),
        .idle          (idle)
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic t_dma_descriptor mk(input int ch, input int tag);
        t_dma_descriptor d;
        d.chan     = t_dma_chan_id'(ch);
        d.src_addr = 32'h1000_0000 + 32'(tag);
        d.dst_addr = 32'h2000_0000 + 32'(tag);
        d.len      = 16'(tag * 4 + 4);
        return d;
    endfunction

    task automatic clr_in();
        desc_in_valid = 1'b0;
        desc_in       = '0;
        ch_desc_ready = '0;
        ch_done       = '0;
        flush         = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clr_in();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_vo(input logic [NCH-1:0] exp, input int limit,
                           input string name);
        int n = 0;
        while (ch_desc_valid !== exp && n < limit) begin
            tick();
            n++;
        end
        chk(name, ch_desc_valid, exp);
    endtask

    // Transaction-level model: accepted-but-unfinished descriptors in order,
    // plus per-channel outstanding counts and a completion total.
    t_dma_descriptor mq[$];
    int              cnt[NCH];
    logic [31:0]     mdone;

    function automatic int sum_cnt();
        int s = 0;
        for (int i = 0; i < NCH; i++) s += cnt[i];
        return s;
    endfunction

    task automatic model_step();
        logic [NCH-1:0]  hsv;
        logic [NCH-1:0]  one;
        t_dma_descriptor e;
        one = 4'b0001;
        hsv = ch_desc_valid & ch_desc_ready;
        if (hsv != '0) begin
            if (mq.size() == 0) begin
                chk("rnd_spurious_offer", hsv, '0);
            end else begin
                e = mq.pop_front();
                chk("rnd_desc", ch_desc, e);
                chk("rnd_onehot", ch_desc_valid, one << e.chan);
                chk("rnd_chan_limit", cnt[e.chan] < MAXC, 1'b1);
                cnt[e.chan]++;
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (ch_done[i]) begin
                cnt[i]--;
                mdone++;
            end
        end
        if (flush) begin
            if (hsv == '0 && ch_desc_valid != '0 && mq.size() > 0) begin
                e = mq[0];
                mq.delete();
                mq.push_back(e);
            end else begin
                mq.delete();
            end
        end else if (desc_in_valid && desc_in_ready) begin
            mq.push_back(desc_in);
        end
    endtask

    typedef struct {
        logic           v;
        int             ch;
        logic [NCH-1:0] rdy;
        logic [NCH-1:0] done;
        logic [NCH-1:0] e_vo;
        int             e_if;
        int             e_dc;
        logic           e_rdy;
        logic           e_idle;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        clr_in();
        do_reset();

        chk("rst_valid", ch_desc_valid, '0);
        chk("rst_desc", ch_desc, '0);
        chk("rst_in_flight", in_flight, '0);
        chk("rst_done_count", done_count, '0);
        chk("rst_bad_chan", bad_chan_err, 1'b0);
        chk("rst_in_ready", desc_in_ready, 1'b1);
        chk("rst_idle", idle, 1'b1);

        // basic dispatch, then three completions alongside a dispatch
        tbl.push_back('{1'b1, 2, 4'hF, 4'h0, 4'b0000, 0, 0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 0, 4'hF, 4'h0, 4'b0100, 0, 0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 0, 4'hF, 4'h0, 4'b0000, 1, 0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 0, 4'hF, 4'b0100, 4'b0000, 0, 1, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 0, 4'hF, 4'h0, 4'b0000, 0, 1, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 3, 4'hF, 4'h0, 4'b0001, 0, 1, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1, 4'hF, 4'h0, 4'b0000, 1, 1, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1, 4'hF, 4'h0, 4'b1000, 1, 1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 0, 4'hF, 4'h0, 4'b0000, 2, 1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 0, 4'hF, 4'h0, 4'b0010, 2, 1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 0, 4'hF, 4'h0, 4'b0000, 3, 1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 0, 4'hF, 4'h0, 4'b0010, 3, 1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 0, 4'hF, 4'b1011, 4'b0000, 1, 4, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 0, 4'hF, 4'b0010, 4'b0000, 0, 5, 1'b1, 1'b1});

        foreach (tbl[k]) begin
            desc_in_valid = tbl[k].v;
            desc_in       = mk(tbl[k].ch, k);
            ch_desc_ready = tbl[k].rdy;
            ch_done       = tbl[k].done;
            tick();
            chk($sformatf("vec%0d_valid", k), ch_desc_valid, tbl[k].e_vo);
            chk($sformatf("vec%0d_in_flight", k), in_flight, tbl[k].e_if);
            chk($sformatf("vec%0d_done", k), done_count, tbl[k].e_dc);
            chk($sformatf("vec%0d_ready", k), desc_in_ready, tbl[k].e_rdy);
            chk($sformatf("vec%0d_idle", k), idle, tbl[k].e_idle);
        end
        clr_in();

        // per-channel limit: the ninth descriptor waits for a credit
        ch_desc_ready = '1;
        for (int k = 0; k < 9; k++) begin
            desc_in_valid = 1'b1;
            desc_in       = mk(0, 100 + k);
            tick();
        end
        desc_in_valid = 1'b0;
        repeat (30) tick();
        chk("limit_in_flight", in_flight, 8);
        chk("limit_blocked", ch_desc_valid, '0);
        chk("limit_not_idle", idle, 1'b0);
        ch_done = 4'b0001;
        tick();
        ch_done = '0;
        chk("limit_credit_back", in_flight, 7);
        chk("limit_not_yet", ch_desc_valid, '0);
        tick();
        chk("limit_dispatch", ch_desc_valid, 4'b0001);
        chk("limit_ninth_desc", ch_desc, mk(0, 108));
        tick();
        chk("limit_in_flight_again", in_flight, 8);
        ch_done = 4'b0001;
        repeat (8) tick();
        ch_done = '0;
        chk("limit_drained", in_flight, 0);
        chk("limit_done_count", done_count, 14);
        chk("limit_idle", idle, 1'b1);

        // completion on an idle channel
        chk("uflow_before", bad_chan_err, 1'b0);
        ch_done = 4'b1000;
        tick();
        ch_done = '0;
        chk("uflow_flag", bad_chan_err, 1'b1);
        chk("uflow_in_flight", in_flight, 0);

        // bad channel is dropped, the next one goes out
        do_reset();
        ch_desc_ready = '1;
        desc_in_valid = 1'b1;
        desc_in       = mk(5, 200);
        tick();
        desc_in       = mk(2, 201);
        tick();
        desc_in_valid = 1'b0;
        wait_vo(4'b0100, 10, "bad_next_dispatch");
        chk("bad_flag", bad_chan_err, 1'b1);
        chk("bad_next_desc", ch_desc, mk(2, 201));
        tick();
        chk("bad_in_flight", in_flight, 1);
        ch_done = 4'b0100;
        tick();
        ch_done = '0;
        chk("bad_in_flight_back", in_flight, 0);
        chk("bad_sticky", bad_chan_err, 1'b1);

        // fill behind a held offer, then flush
        ch_desc_ready = '0;
        desc_in_valid = 1'b1;
        desc_in       = mk(1, 300);
        tick();
        desc_in_valid = 1'b0;
        wait_vo(4'b0010, 5, "full_first_offer");
        for (int k = 0; k < DEPTH; k++) begin
            chk($sformatf("full_ready_%0d", k), desc_in_ready, 1'b1);
            desc_in_valid = 1'b1;
            desc_in       = mk(1, 301 + k);
            tick();
        end
        desc_in = mk(1, 399);
        chk("full_ready_low", desc_in_ready, 1'b0);
        tick();
        chk("full_ready_stays_low", desc_in_ready, 1'b0);
        flush   = 1'b1;
        desc_in = mk(1, 398);
        tick();
        flush         = 1'b0;
        desc_in_valid = 1'b0;
        chk("flush_ready", desc_in_ready, 1'b1);
        chk("flush_offer_kept", ch_desc_valid, 4'b0010);
        chk("flush_offer_desc", ch_desc, mk(1, 300));
        chk("flush_not_idle", idle, 1'b0);
        desc_in_valid = 1'b1;
        flush         = 1'b1;
        desc_in       = mk(1, 397);
        tick();
        desc_in_valid = 1'b0;
        flush         = 1'b0;
        ch_desc_ready = 4'b0010;
        tick();
        chk("flush_held_done", in_flight, 1);
        repeat (5) tick();
        chk("flush_no_leftover", ch_desc_valid, '0);
        ch_done = 4'b0010;
        tick();
        ch_done = '0;
        chk("flush_idle", idle, 1'b1);

        // asynchronous reset while an offer is held
        ch_desc_ready = 4'b0001;
        desc_in_valid = 1'b1;
        desc_in       = mk(0, 401);
        tick();
        desc_in       = mk(3, 400);
        tick();
        desc_in_valid = 1'b0;
        wait_vo(4'b1000, 8, "arst_offer");
        chk("arst_in_flight_pre", in_flight, 1);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_valid", ch_desc_valid, '0);
        chk("arst_desc", ch_desc, '0);
        chk("arst_in_flight", in_flight, 0);
        chk("arst_done_count", done_count, 0);
        chk("arst_bad_chan", bad_chan_err, 1'b0);
        chk("arst_ready", desc_in_ready, 1'b1);
        chk("arst_idle", idle, 1'b1);
        do_reset();

        // random traffic against the model
        mq.delete();
        for (int i = 0; i < NCH; i++) cnt[i] = 0;
        mdone = '0;
        for (int it = 0; it < 3000; it++) begin
            chk("rnd_in_flight", in_flight, sum_cnt());
            chk("rnd_done_count", done_count, mdone);
            chk("rnd_ready", desc_in_ready,
                (mq.size() - (ch_desc_valid != '0 ? 1 : 0)) < DEPTH);
            chk("rnd_idle", idle, mq.size() == 0 && sum_cnt() == 0);
            desc_in_valid = $urandom_range(0, 9) < 6;
            desc_in       = mk($urandom_range(0, NCH - 1),
                               int'($urandom_range(0, 65535)));
            for (int c = 0; c < NCH; c++) begin
                ch_desc_ready[c] = $urandom_range(0, 9) < 7;
                ch_done[c]       = cnt[c] > 0 && $urandom_range(0, 9) < 3;
            end
            flush = $urandom_range(0, 199) == 0;
            model_step();
            tick();
        end

        desc_in_valid = 1'b0;
        flush         = 1'b0;
        ch_desc_ready = '1;
        for (int n = 0; n < 300; n++) begin
            if (mq.size() == 0 && sum_cnt() == 0) break;
            for (int c = 0; c < NCH; c++) ch_done[c] = cnt[c] > 0;
            model_step();
            tick();
        end
        ch_done = '0;
        tick();
        chk("drain_queue_empty", mq.size(), 0);
        chk("drain_in_flight", in_flight, 0);
        chk("drain_done_count", done_count, mdone);
        chk("drain_idle", idle, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
